mem_bus_arb2: RTL and testbench
===============================

# mem_bus_arb2

Two-master arbiter for the picorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata). It lets the CPU core and a second bus master, e.g. a DMA or debug port, share one downstream slave bus. That slave bus is the existing address-decoded memory/i2cm fabric. Grants are round-robin, one transaction at a time, and a watchdog returns an error word if a slave never answers.

## Interface
- TIMEOUT, 255: BUSY cycles without s_ready before the transaction is force-completed; legal range 2..65535.
- ERR_RDATA, 32'hDEADBEEF: rdata returned to the master on timeout.
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_valid / m1_valid  in  1  master request.
- m0_ready / m1_ready  out  1  transaction complete (one cycle).
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read.
- m0_rdata / m1_rdata  out  32  read data, valid while mX_ready=1.
- s_valid  out  1  request to slave fabric.
- s_ready  in  1  slave completion.
- s_addr / s_wdata / s_wstrb  out  32/32/4  forwarded from the granted master.
- s_rdata  in  32  slave read data.
- err  out  1  one-cycle pulse, registered, the cycle after a timeout completion.
- err_addr  out  32  address of the last timed-out transaction; holds until the next timeout.

## Operation
- States: IDLE, BUSY. Registers: state, gnt (0 = m0, 1 = m1), last (last granted master), cnt (16 bit), err, err_addr.
- IDLE: s_valid=0, both mX_ready=0.
  - If exactly one mX_valid is high, set gnt to X.
  - If both are high, set gnt to !last.
  - Go to BUSY on the next edge. With no request, stay in IDLE.
- BUSY, combinational pass-through from the granted master:
  - s_valid = m[gnt]_valid.
  - s_addr/s_wdata/s_wstrb = m[gnt] fields.
  - m[gnt]_rdata = s_rdata; the non-granted rdata = 0.
  - m[gnt]_ready = s_ready & s_valid; the non-granted ready = 0 always.
- Completion: s_valid & s_ready. On the next edge: go to IDLE, last<=gnt, cnt<=0.
- Timeout: in BUSY with cnt==TIMEOUT-1 and no s_ready (the timeout cycle):
  - force s_valid=0, m[gnt]_ready=1, m[gnt]_rdata=ERR_RDATA.
  - next edge: go to IDLE, last<=gnt, err<=1, err_addr<=m[gnt]_addr.
  - otherwise cnt increments every BUSY cycle.
- Abort: if m[gnt]_valid drops in BUSY (protocol violation), return to IDLE next edge. No ready is issued, last is unchanged, cnt<=0.
- s_ready arriving in the timeout cycle: normal completion wins; no error.
- The non-granted master's outputs stay 0 and its request waits. No request is lost, because picorv32 holds valid until ready.
- s_addr/s_wdata/s_wstrb are don't-care while s_valid=0; drive them from m[gnt].
- Reset values: state=IDLE, gnt=0, last=1 (so m0 wins the first tie), cnt=0, err=0, err_addr=0. Hence s_valid=0, m0_ready=m1_ready=0, rdata=0.
- Reset mid-transaction abandons it immediately. No ready is issued, and the slave sees s_valid fall asynchronously.

## Timing
- Request at cycle N in IDLE: s_valid at N+1. A zero-wait slave completes at N+1 (m ready in the same cycle as s_ready).
- Back-to-back throughput: one transaction per 2 cycles minimum; IDLE is always one cycle between grants.
- Ready path is combinational s_ready -> mX_ready; there is no registered stage in the data path.
- Timeout completes at exactly N+TIMEOUT; err is high at N+TIMEOUT+1 for one cycle.
- Fairness: with both masters requesting continuously, grants strictly alternate.

## Structure
- Shared package mem_bus_pkg: state enum (IDLE, BUSY), MEM_AW=32, MEM_DW=32, MEM_SW=4, default ERR_RDATA. The same constants will be used by future bus blocks.
- One natural sub-module: rr_arb2. It is combinational: inputs req[1:0] and last, output gnt. It is instantiated once and reusable for other 2-way shares.

## Test plan
- Single request: m0 read at 32'h0000_0100, slave ready on its first cycle -> s_valid at N+1, m0_ready=1 at N+1, m0_rdata=s_rdata, m1 outputs stay 0.
- Simultaneous: m0 and m1 both request from reset -> m0 granted first, then m1, then alternating m0/m1/m0 over 6 transactions.
- Write forwarding: m1 writes 32'hA5A5_1234 to 32'h5000_0004 with wstrb 4'b0011 -> identical s_addr/s_wdata/s_wstrb while s_valid, single m1_ready pulse.
- Timeout: TIMEOUT=8, m0 read to 32'h7000_0000, s_ready tied 0 -> m0_ready at N+8 with rdata 32'hDEADBEEF; err pulse at N+9; err_addr=32'h7000_0000; m1 is granted next.
- Boundary: s_ready first asserted in the timeout cycle -> normal completion, real s_rdata, no err.
- Reset mid-transaction: assert rst_n=0 during BUSY with a stalled slave -> s_valid and all readys 0 immediately; after release the first tie goes to m0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants, state encoding and request payload for native memory bus blocks.
package mem_bus_pkg;

  localparam int unsigned MEM_AW = 32;
  localparam int unsigned MEM_DW = 32;
  localparam int unsigned MEM_SW = 4;

  localparam logic [MEM_DW-1:0] ERR_RDATA_DEF = 32'hDEADBEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
    logic [MEM_SW-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o
);

  always_comb begin
    gnt_o = 1'b0;
    case (req_i)
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arb2.sv
// Two-master round-robin arbiter for the picorv32 native bus with a no-response watchdog.
module mem_bus_arb2
  import mem_bus_pkg::*;
#(
  parameter int unsigned       TIMEOUT   = 255,
  parameter logic [MEM_DW-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [MEM_AW-1:0] m0_addr,
  input  logic [MEM_DW-1:0] m0_wdata,
  input  logic [MEM_SW-1:0] m0_wstrb,
  output logic [MEM_DW-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [MEM_AW-1:0] m1_addr,
  input  logic [MEM_DW-1:0] m1_wdata,
  input  logic [MEM_SW-1:0] m1_wstrb,
  output logic [MEM_DW-1:0] m1_rdata,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [MEM_AW-1:0] s_addr,
  output logic [MEM_DW-1:0] s_wdata,
  output logic [MEM_SW-1:0] s_wstrb,
  input  logic [MEM_DW-1:0] s_rdata,
  output logic              err,
  output logic [MEM_AW-1:0] err_addr
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [MEM_AW-1:0] err_addr_q, err_addr_d;

  logic              arb_gnt;
  logic              busy;
  logic              sel_valid;
  mem_req_t          sel_req;
  logic              to_hit;
  logic              s_done;
  logic              m_ack;
  logic [MEM_DW-1:0] m_rdata;

  rr_arb2 u_rr_arb2 (
    .req_i  ({m1_valid, m0_valid}),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // Granted master's request, also driven onto the slave bus while idle.
  always_comb begin
    if (gnt_q) begin
      sel_valid = m1_valid;
      sel_req   = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
    end else begin
      sel_valid = m0_valid;
      sel_req   = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    end
  end

  // A late s_ready in the last watchdog cycle still completes normally, so the
  // slave must not derive s_ready combinationally from s_valid.
  assign busy    = (state_q == BUSY);
  assign to_hit  = busy & sel_valid & ~s_ready & (cnt_q == CNT_LAST);
  assign s_valid = busy & sel_valid & ~to_hit;
  assign s_done  = s_valid & s_ready;
  assign m_ack   = s_done | to_hit;
  assign m_rdata = to_hit ? ERR_RDATA : s_rdata;

  assign s_addr   = sel_req.addr;
  assign s_wdata  = sel_req.wdata;
  assign s_wstrb  = sel_req.wstrb;

  assign m0_ready = m_ack & ~gnt_q;
  assign m1_ready = m_ack & gnt_q;
  assign m0_rdata = (busy & ~gnt_q) ? m_rdata : '0;
  assign m1_rdata = (busy & gnt_q) ? m_rdata : '0;

  assign err      = err_q;
  assign err_addr = err_addr_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (m0_valid | m1_valid) begin
          gnt_d   = arb_gnt;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!sel_valid) begin
          // Master withdrew its request: drop it without a ready, keep fairness history.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s_done) begin
          state_d = IDLE;
          last_d  = gnt_q;
          cnt_d   = '0;
        end else if (to_hit) begin
          state_d    = IDLE;
          last_d     = gnt_q;
          cnt_d      = '0;
          err_d      = 1'b1;
          err_addr_d = sel_req.addr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arb2.sv
// Scoreboard bench for mem_bus_arb2: directed transactions, slave with settable latency.
module tb_mem_bus_arb2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        err;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  mem_bus_arb2 #(.TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .err(err), .err_addr(err_addr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          lat;
    logic        to;
  } exp_t;

  req_t        q0[$];
  req_t        q1[$];
  exp_t        expq[$];
  logic [31:0] errq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise0 = 0, rise1 = 0;
  int   to_cyc = -10;
  int   idle_cnt = 0;
  int   scnt = 0;
  int   slv_lat = 0;
  logic slv_en = 1'b1;
  logic kill = 1'b0;
  logic done = 1'b0;
  logic fin = 1'b0;

  // Slave: answers after slv_lat cycles of s_valid; read data is the inverted address.
  assign s_ready = slv_en && (scnt == slv_lat);
  assign s_rdata = ~s_addr;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) scnt <= (s_valid && !s_ready) ? scnt + 1 : 0;

  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s, input logic [31:0] rd, input int lat,
                       input logic to, input logic ex);
    req_t r;
    exp_t e;
    r.addr = a; r.wdata = w; r.wstrb = s;
    if (id) q1.push_back(r);
    else    q0.push_back(r);
    if (ex) begin
      e.id = id; e.addr = a; e.wdata = w; e.wstrb = s;
      e.rdata = rd; e.lat = lat; e.to = to;
      expq.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && q0.size() == 0 && q1.size() == 0 && !m0_valid && !m1_valid) break;
    end
    @(negedge clk);
  endtask

  // Master driver: holds valid until ready, then presents the next queued request.
  initial begin
    logic d0, d1;
    req_t t;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    forever begin
      @(negedge clk);
      d0 = m0_ready;
      d1 = m1_ready;
      @(posedge clk);
      #1;
      if (kill) begin
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        q0.delete();
        q1.delete();
      end else begin
        if (d0) m0_valid = 1'b0;
        if (d1) m1_valid = 1'b0;
        if (!m0_valid && q0.size() > 0) begin
          t = q0.pop_front();
          m0_addr = t.addr; m0_wdata = t.wdata; m0_wstrb = t.wstrb;
          m0_valid = 1'b1; rise0 = cyc;
        end
        if (!m1_valid && q1.size() > 0) begin
          t = q1.pop_front();
          m1_addr = t.addr; m1_wdata = t.wdata; m1_wstrb = t.wstrb;
          m1_valid = 1'b1; rise1 = cyc;
        end
      end
    end
  end

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endfunction

  // Monitor: pops the scoreboard on every ready and on every err pulse.
  exp_t        me;
  logic [31:0] mea;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_valid", {31'b0, s_valid}, 32'd0);
      chk("rst_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      chk("rst_m1_rdata", m1_rdata, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
    end else begin
      if (m0_ready || m1_ready) begin
        idle_cnt = 0;
        if (expq.size() == 0) begin
          chk("ready_spurious", {30'b0, m1_ready, m0_ready}, 32'd0);
        end else begin
          me = expq.pop_front();
          chk("ready_both", {31'b0, m0_ready & m1_ready}, 32'd0);
          chk("gnt_id", {31'b0, m1_ready}, {31'b0, me.id});
          chk("rdata", me.id ? m1_rdata : m0_rdata, me.rdata);
          chk("other_rdata", me.id ? m0_rdata : m1_rdata, 32'd0);
          if (me.lat >= 0)
            chk("latency", 32'(cyc - (me.id ? rise1 : rise0)), 32'(me.lat));
          if (me.to) begin
            chk("to_s_valid", {31'b0, s_valid}, 32'd0);
            to_cyc = cyc;
          end else begin
            chk("s_valid", {31'b0, s_valid}, 32'd1);
            chk("s_addr", s_addr, me.addr);
            chk("s_wdata", s_wdata, me.wdata);
            chk("s_wstrb", {28'b0, s_wstrb}, {28'b0, me.wstrb});
          end
        end
      end else if (expq.size() > 0) begin
        idle_cnt++;
        if (idle_cnt > 40) begin
          chk("ready_wait", 32'(expq.size()), 32'd0);
          expq.delete();
          idle_cnt = 0;
        end
      end
      if (err) begin
        if (errq.size() == 0) begin
          chk("err_spurious", {31'b0, err}, 32'd0);
        end else begin
          mea = errq.pop_front();
          chk("err_addr", err_addr, mea);
          chk("err_cycle", 32'(cyc), 32'(to_cyc + 1));
        end
      end
    end
    if (done && !fin) begin
      chk("exp_left", 32'(expq.size()), 32'd0);
      chk("err_left", 32'(errq.size()), 32'd0);
      fin = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie from reset: m0 first, then strict alternation.
    issue(0, 32'h1000_0000, 32'h0, 4'h0, 32'hEFFF_FFFF, 1, 1'b0, 1'b1);
    issue(1, 32'h2000_0010, 32'h0, 4'h0, 32'hDFFF_FFEF, 3, 1'b0, 1'b1);
    issue(0, 32'h1000_0004, 32'h0, 4'h0, 32'hEFFF_FFFB, 3, 1'b0, 1'b1);
    issue(1, 32'h2000_0014, 32'h0, 4'h0, 32'hDFFF_FFEB, 3, 1'b0, 1'b1);
    issue(0, 32'h1000_0008, 32'h0, 4'h0, 32'hEFFF_FFF7, 3, 1'b0, 1'b1);
    issue(1, 32'h2000_0018, 32'h0, 4'h0, 32'hDFFF_FFE7, 3, 1'b0, 1'b1);
    drain();

    issue(0, 32'h0000_0100, 32'h0, 4'h0, 32'hFFFF_FEFF, 1, 1'b0, 1'b1);
    drain();

    issue(1, 32'h5000_0004, 32'hA5A5_1234, 4'b0011, 32'hAFFF_FFFB, 1, 1'b0, 1'b1);
    drain();

    // Dead slave: m0 times out, waiting m1 is served next.
    slv_en = 1'b0;
    issue(0, 32'h7000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 8, 1'b1, 1'b1);
    errq.push_back(32'h7000_0000);
    repeat (2) @(negedge clk);
    issue(1, 32'h3000_0000, 32'h0, 4'h0, 32'hCFFF_FFFF, 8, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    slv_en = 1'b1;
    drain();

    // Slave answers exactly in the watchdog's last cycle.
    slv_lat = 7;
    issue(0, 32'h0000_0200, 32'h0, 4'h0, 32'hFFFF_FDFF, 8, 1'b0, 1'b1);
    drain();
    slv_lat = 0;

    // Reset while a transaction is stalled.
    slv_en = 1'b0;
    issue(1, 32'h6000_0000, 32'h0, 4'h0, 32'h0, -1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    kill  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    kill   = 1'b0;
    slv_en = 1'b1;
    @(negedge clk);
    issue(0, 32'h0000_0400, 32'h0, 4'h0, 32'hFFFF_FBFF, 1, 1'b0, 1'b1);
    issue(1, 32'h0000_0800, 32'h0, 4'h0, 32'hFFFF_F7FF, 3, 1'b0, 1'b1);
    drain();

    done = 1'b1;
    for (int i = 0; i < 5 && !fin; i++) @(negedge clk);
    if (!fin) begin
      $display("FAIL monitor_final act=0 exp=1");
      $fatal(1, "monitor did not complete");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
